systolic_ctrl: RTL and testbench
================================

// Module: systolic_ctrl
// PURPOSE
//  Sequencer for the NxN bit-serial FP-INT systolic array: accepts one tile job (K activation vectors,
//  weight precision, shared exponent). Drives activation/weight buffer reads, the array's active/precision/
//  exp_set controls and an accumulator-clear pulse. Waits out pipeline drain, then presents a
//  result-valid handshake. Sits between the job/DMA front end and the systolic array + its input buffers.
// PARAMETERS
//  N          2   array dimension (rows = cols)
//  K_W        8   width of vector-count field (K up to 2^K_W-1)
//  ADDR_W     10  activation/weight buffer address width
//  MAX_PREC   8   largest legal weight precision (bits)
//  DRAIN_LAT  6   cycles after last active beat until acc_out is final (2N+2 for N=2)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  cfg_valid      in   1       job request
//  cfg_ready      out  1       high only in IDLE
//  cfg_k          in   K_W     number of activation vectors K
//  cfg_precision  in   4       weight bits per vector P
//  cfg_exp_set    in   5       shared exponent for the tile
//  cfg_act_base   in   ADDR_W  activation buffer base address
//  cfg_w_base     in   ADDR_W  weight buffer base address
//  abort          in   1       synchronous job cancel
//  act_rd_en      out  1       activation buffer read strobe (1-cycle read latency)
//  act_rd_addr    out  ADDR_W  activation read address
//  w_rd_en        out  1       weight buffer read strobe (N weight bits per word)
//  w_rd_addr      out  ADDR_W  weight read address
//  arr_clr        out  1       1-cycle accumulator clear to array
//  arr_active     out  1       array active, aligned with buffer read data
//  arr_precision  out  4       latched P
//  arr_exp_set    out  5       latched exponent
//  busy           out  1       high in any state but IDLE
//  cfg_err        out  1       1-cycle pulse: job rejected
//  res_valid      out  1       results final on array acc_out/exp_out
//  res_ready      in   1       consumer has read results
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except cfg_ready=1. arr_precision/arr_exp_set = 0. Counters cleared.
//  FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
//  IDLE: accept on cfg_valid&cfg_ready; latch cfg_* fields.
//   If P==0, P>MAX_PREC or K==0: pulse cfg_err next cycle and stay IDLE, with no other output activity.
//  CLEAR: 1 cycle, arr_clr=1.
//  FEED: K*P cycles. Each cycle: w_rd_en=1, w_rd_addr = w_base + running beat count.
//   act_rd_en=1 only on bit 0 of each vector, act_rd_addr = act_base + vector index.
//   Bit counter wraps P-1 -> 0 and advances vector index. Exit after beat K*P-1.
//  arr_active = FEED registered once, so it is high for exactly K*P consecutive cycles, 1 cycle after FEED.
//  DRAIN: DRAIN_LAT+1 cycles; no reads; arr_active drops after its final delayed beat.
//  DONE: res_valid=1, held until res_ready; same-cycle res_valid&res_ready -> IDLE next cycle.
//  Latency: accept at cycle t -> arr_clr at t+1, FEED t+2..t+1+K*P, res_valid first high at t+3+K*P+DRAIN_LAT.
//  cfg_valid outside IDLE is ignored (cfg_ready=0), never queued.
//  Address adds wrap modulo 2^ADDR_W.
//  abort in any non-IDLE state: next cycle IDLE, all strobes/arr_active/res_valid low, no cfg_err.
//   abort has priority over res_ready. abort in IDLE has no effect.
//  rst has priority over abort and applies mid-job identically to power-on reset.
//  arr_precision/arr_exp_set stay stable from CLEAR through DONE and change only on the next accept.
// TESTING
//  1 K=2,P=4,exp=15,bases 0: arr_clr@t+1; w_rd_addr 0..7; act_rd_en at beats 0,4 (addr 0,1); arr_active t+3..t+10; res_valid@t+17.
//  2 P=0, then P=9, then K=0 -> cfg_err pulse each; busy, rd strobes, arr_active all stay 0.
//  3 res_ready held low 20 cycles in DONE -> res_valid held; cfg_valid meanwhile ignored; res_ready -> IDLE next.
//  4 abort mid-FEED (beat 3) -> next cycle all strobes and arr_active 0, busy 0, cfg_ready 1, no res_valid.
//  5 rst pulse mid-DRAIN -> reset values next cycle; a following job K=1,P=1 gives res_valid at t+4+DRAIN_LAT.
//  6 w_base=2^ADDR_W-2, K=1,P=4 -> w_rd_addr sequence 1022,1023,0,1 (ADDR_W=10); back-to-back jobs accepted the cycle after DONE.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: tile-job sequencer for the NxN bit-serial FP-INT systolic array.
// Accepts one job (K activation vectors, weight precision P, shared exponent),
// clears the accumulators, streams K*P weight beats with one activation read per
// vector, waits for the array pipeline to drain, then holds a result handshake.
module systolic_ctrl #(
  parameter int N         = 2,
  parameter int K_W       = 8,
  parameter int ADDR_W    = 10,
  parameter int MAX_PREC  = 8,
  parameter int DRAIN_LAT = 2 * N + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [K_W-1:0]    cfg_k,
  input  logic [3:0]        cfg_precision,
  input  logic [4:0]        cfg_exp_set,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic              abort,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              arr_clr,
  output logic              arr_active,
  output logic [3:0]        arr_precision,
  output logic [4:0]        arr_exp_set,
  output logic              busy,
  output logic              cfg_err,
  output logic              res_valid,
  input  logic              res_ready
);

  localparam logic [3:0] LP_MAX_PREC = 4'(MAX_PREC);
  localparam int         LP_DRAIN_W  = $clog2(DRAIN_LAT + 2);
  localparam logic [LP_DRAIN_W-1:0] LP_DRAIN_END = LP_DRAIN_W'(DRAIN_LAT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched job description
  logic [K_W-1:0]    r_k;
  logic [3:0]        r_prec;
  logic [4:0]        r_exp;
  logic [ADDR_W-1:0] r_act_base;
  logic [ADDR_W-1:0] r_w_base;

  // FEED sequencing counters
  logic [3:0]        r_bit;
  logic [K_W-1:0]    r_vec;
  logic [ADDR_W-1:0] r_beat;
  logic [LP_DRAIN_W-1:0] r_drain;

  logic r_arr_active;
  logic r_cfg_err;

  logic w_cfg_ok;
  logic w_accept;
  logic w_last_beat;
  logic w_bit_wrap;

  assign w_cfg_ok    = (cfg_k != '0) && (cfg_precision != '0) &&
                       (cfg_precision <= LP_MAX_PREC);
  assign w_accept    = (r_state == S_IDLE) && cfg_valid && w_cfg_ok;
  assign w_bit_wrap  = (r_bit == (r_prec - 4'd1));
  assign w_last_beat = w_bit_wrap && (r_vec == (r_k - K_W'(1)));

  assign arr_active    = r_arr_active;
  assign cfg_err       = r_cfg_err;
  assign arr_precision = r_prec;
  assign arr_exp_set   = r_exp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs; abort overrides every non-IDLE transition
  always_comb begin
    w_next      = r_state;
    cfg_ready   = 1'b0;
    busy        = 1'b1;
    arr_clr     = 1'b0;
    w_rd_en     = 1'b0;
    w_rd_addr   = '0;
    act_rd_en   = 1'b0;
    act_rd_addr = '0;
    res_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid && w_cfg_ok) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        arr_clr = 1'b1;
        w_next  = S_FEED;
      end
      S_FEED: begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_w_base + r_beat;
        if (r_bit == 4'd0) begin
          act_rd_en   = 1'b1;
          act_rd_addr = r_act_base + ADDR_W'(r_vec);
        end
        if (w_last_beat) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain == LP_DRAIN_END) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end
  end

  // Latch job fields only on a legal accept so the array controls stay stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k        <= '0;
      r_prec     <= '0;
      r_exp      <= '0;
      r_act_base <= '0;
      r_w_base   <= '0;
    end else if (w_accept) begin
      r_k        <= cfg_k;
      r_prec     <= cfg_precision;
      r_exp      <= cfg_exp_set;
      r_act_base <= cfg_act_base;
      r_w_base   <= cfg_w_base;
    end
  end

  // Bit/vector/beat counters: bit wraps at P-1 and advances the vector index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit  <= '0;
      r_vec  <= '0;
      r_beat <= '0;
    end else if (r_state == S_CLEAR) begin
      r_bit  <= '0;
      r_vec  <= '0;
      r_beat <= '0;
    end else if (r_state == S_FEED) begin
      r_beat <= r_beat + ADDR_W'(1);
      if (w_bit_wrap) begin
        r_bit <= '0;
        r_vec <= r_vec + K_W'(1);
      end else begin
        r_bit <= r_bit + 4'd1;
      end
    end
  end

  // Drain timer counts 0..DRAIN_LAT while in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain <= '0;
    end else if (r_state == S_DRAIN) begin
      r_drain <= r_drain + LP_DRAIN_W'(1);
    end else begin
      r_drain <= '0;
    end
  end

  // arr_active is FEED delayed one cycle to line up with buffer read data;
  // an abort suppresses the trailing beat so it drops together with the abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arr_active <= 1'b0;
    end else begin
      r_arr_active <= (r_state == S_FEED) && !abort;
    end
  end

  // One-cycle rejection pulse for an illegal job offered in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= (r_state == S_IDLE) && cfg_valid && !w_cfg_ok;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: per-scenario tasks with a queue-based scoreboard of
// expected buffer addresses and timing, filled at job submission.
module tb_systolic_ctrl;

  localparam int K_W    = 8;
  localparam int ADDR_W = 10;
  localparam int DL     = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [K_W-1:0]    cfg_k;
  logic [3:0]        cfg_precision;
  logic [4:0]        cfg_exp_set;
  logic [ADDR_W-1:0] cfg_act_base;
  logic [ADDR_W-1:0] cfg_w_base;
  logic              abort;
  logic              act_rd_en;
  logic [ADDR_W-1:0] act_rd_addr;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              arr_clr;
  logic              arr_active;
  logic [3:0]        arr_precision;
  logic [4:0]        arr_exp_set;
  logic              busy;
  logic              cfg_err;
  logic              res_valid;
  logic              res_ready;

  systolic_ctrl #(
    .N        (2),
    .K_W      (K_W),
    .ADDR_W   (ADDR_W),
    .MAX_PREC (8),
    .DRAIN_LAT(DL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_k        (cfg_k),
    .cfg_precision(cfg_precision),
    .cfg_exp_set  (cfg_exp_set),
    .cfg_act_base (cfg_act_base),
    .cfg_w_base   (cfg_w_base),
    .abort        (abort),
    .act_rd_en    (act_rd_en),
    .act_rd_addr  (act_rd_addr),
    .w_rd_en      (w_rd_en),
    .w_rd_addr    (w_rd_addr),
    .arr_clr      (arr_clr),
    .arr_active   (arr_active),
    .arr_precision(arr_precision),
    .arr_exp_set  (arr_exp_set),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .res_valid    (res_valid),
    .res_ready    (res_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int t_acc  = 0;

  logic [ADDR_W-1:0] exp_w[$];
  logic [ADDR_W-1:0] obs_w[$];
  logic [ADDR_W-1:0] exp_a[$];
  logic [ADDR_W-1:0] obs_a[$];
  int exp_ab[$];
  int obs_ab[$];
  int exp_rv;
  int exp_act_cnt;
  int o_clr_first, o_clr_cnt, o_act_first, o_act_last, o_act_cnt, o_rv;

  // Called just after a rising edge: offers a job for one cycle and records
  // the expected address streams and result timing for it.
  task automatic submit(input int k, input int p, input int e, input int ab, input int wb);
    cfg_k         = K_W'(k);
    cfg_precision = 4'(p);
    cfg_exp_set   = 5'(e);
    cfg_act_base  = ADDR_W'(ab);
    cfg_w_base    = ADDR_W'(wb);
    cfg_valid     = 1'b1;
    t_acc         = cyc;
    exp_w.delete();
    exp_a.delete();
    exp_ab.delete();
    exp_rv      = -1;
    exp_act_cnt = 0;
    if (k > 0 && p > 0 && p <= 8) begin
      for (int b = 0; b < k * p; b++) exp_w.push_back(ADDR_W'(wb + b));
      for (int v = 0; v < k; v++) begin
        exp_a.push_back(ADDR_W'(ab + v));
        exp_ab.push_back(v * p);
      end
      exp_rv      = 3 + k * p + DL;
      exp_act_cnt = k * p;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Records DUT activity per cycle (relative to the accept cycle) until res_valid.
  task automatic capture(input int maxc);
    int beats;
    int rel;
    beats = 0;
    obs_w.delete();
    obs_a.delete();
    obs_ab.delete();
    o_clr_first = -1; o_clr_cnt = 0;
    o_act_first = -1; o_act_last = -1; o_act_cnt = 0;
    o_rv = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      rel = cyc - t_acc;
      if (arr_clr) begin
        if (o_clr_first < 0) o_clr_first = rel;
        o_clr_cnt++;
      end
      if (act_rd_en) begin
        obs_a.push_back(act_rd_addr);
        obs_ab.push_back(beats);
      end
      if (w_rd_en) begin
        obs_w.push_back(w_rd_addr);
        beats++;
      end
      if (arr_active) begin
        if (o_act_first < 0) o_act_first = rel;
        o_act_last = rel;
        o_act_cnt++;
      end
      if (res_valid) begin
        o_rv = rel;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    n_cmp++;
    if ({busy, act_rd_en, w_rd_en, arr_clr, arr_active, cfg_err, res_valid} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {busy, act_rd_en, w_rd_en, arr_clr, arr_active, cfg_err, res_valid});
    end
    n_cmp++;
    if ({arr_precision, arr_exp_set, act_rd_addr, w_rd_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: got prec=%0d exp=%0d aaddr=%0d waddr=%0d expected all 0",
               arr_precision, arr_exp_set, act_rd_addr, w_rd_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic_job();
    logic [ADDR_W-1:0] e, o;
    int eb, ob;
    @(posedge clk); #1;
    submit(2, 4, 15, 0, 0);
    capture(60);
    n_cmp++;
    if (o_clr_first !== 1) begin n_fail++; $display("FAIL basic_clr_cycle: got %0d expected 1", o_clr_first); end
    n_cmp++;
    if (o_clr_cnt !== 1) begin n_fail++; $display("FAIL basic_clr_len: got %0d expected 1", o_clr_cnt); end
    for (int i = 0; exp_w.size() > 0; i++) begin
      e = exp_w.pop_front();
      n_cmp++;
      if (obs_w.size() == 0) begin
        n_fail++; $display("FAIL basic_w_addr[%0d]: got none expected %0d", i, e);
      end else begin
        o = obs_w.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL basic_w_addr[%0d]: got %0d expected %0d", i, o, e); end
      end
    end
    n_cmp++;
    if (obs_w.size() != 0) begin n_fail++; $display("FAIL basic_w_extra: got %0d extra expected 0", obs_w.size()); end
    for (int i = 0; exp_a.size() > 0; i++) begin
      e  = exp_a.pop_front();
      eb = exp_ab.pop_front();
      n_cmp++;
      if (obs_a.size() == 0) begin
        n_fail++; $display("FAIL basic_act[%0d]: got none expected addr %0d beat %0d", i, e, eb);
      end else begin
        o  = obs_a.pop_front();
        ob = obs_ab.pop_front();
        if (o !== e || ob !== eb) begin
          n_fail++;
          $display("FAIL basic_act[%0d]: got addr %0d beat %0d expected addr %0d beat %0d", i, o, ob, e, eb);
        end
      end
    end
    n_cmp++;
    if (obs_a.size() != 0) begin n_fail++; $display("FAIL basic_act_extra: got %0d extra expected 0", obs_a.size()); end
    n_cmp++;
    if (o_act_first !== 3) begin n_fail++; $display("FAIL basic_active_first: got %0d expected 3", o_act_first); end
    n_cmp++;
    if (o_act_cnt !== exp_act_cnt) begin n_fail++; $display("FAIL basic_active_cnt: got %0d expected %0d", o_act_cnt, exp_act_cnt); end
    n_cmp++;
    if (o_act_last !== 10) begin n_fail++; $display("FAIL basic_active_last: got %0d expected 10", o_act_last); end
    n_cmp++;
    if (o_rv !== exp_rv) begin n_fail++; $display("FAIL basic_res_valid_cycle: got %0d expected %0d", o_rv, exp_rv); end
    n_cmp++;
    if (arr_precision !== 4'd4 || arr_exp_set !== 5'd15) begin
      n_fail++; $display("FAIL basic_latched: got prec=%0d exp=%0d expected prec=4 exp=15", arr_precision, arr_exp_set);
    end
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_flags: got busy=%0b ready=%0b expected busy=1 ready=0", busy, cfg_ready);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_return_idle: got rv=%0b ready=%0b expected rv=0 ready=1", res_valid, cfg_ready);
    end
  endtask

  task automatic test_bad_cfg();
    int ks[3] = '{2, 2, 0};
    int ps[3] = '{0, 9, 4};
    int errs, err_at, act;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      submit(ks[j], ps[j], 1, 0, 0);
      errs = 0; err_at = -1; act = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (cfg_err) begin
          errs++;
          if (err_at < 0) err_at = cyc - t_acc;
        end
        if (busy || act_rd_en || w_rd_en || arr_active || arr_clr || res_valid || !cfg_ready) act++;
      end
      n_cmp++;
      if (errs !== 1 || err_at !== 1) begin
        n_fail++; $display("FAIL bad_cfg[%0d]_err: got %0d pulses at %0d expected 1 pulse at 1", j, errs, err_at);
      end
      n_cmp++;
      if (act !== 0) begin n_fail++; $display("FAIL bad_cfg[%0d]_activity: got %0d active cycles expected 0", j, act); end
    end
  endtask

  task automatic test_hold_done();
    int held, stray;
    @(posedge clk); #1;
    submit(1, 2, 4, 7, 8);
    capture(60);
    n_cmp++;
    if (o_rv !== exp_rv) begin n_fail++; $display("FAIL hold_res_valid_cycle: got %0d expected %0d", o_rv, exp_rv); end
    cfg_k = 8'd1; cfg_precision = 4'd1; cfg_valid = 1'b1;
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid && !cfg_ready && busy) held++;
    end
    n_cmp++;
    if (held !== 20) begin n_fail++; $display("FAIL hold_res_valid: got %0d cycles expected 20", held); end
    cfg_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got rv=%0b ready=%0b expected rv=0 ready=1", res_valid, cfg_ready);
    end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (arr_clr || busy) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin n_fail++; $display("FAIL hold_no_queued_job: got %0d busy cycles expected 0", stray); end
  endtask

  task automatic test_abort();
    int beats, found, bad;
    logic [ADDR_W-1:0] a3;
    @(posedge clk); #1;
    submit(2, 4, 2, 5, 9);
    beats = 0; found = 0; a3 = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w_rd_en) begin
        if (beats == 3) begin found = 1; a3 = w_rd_addr; break; end
        beats++;
      end
    end
    n_cmp++;
    if (found !== 1) begin n_fail++; $display("FAIL abort_reach_beat3: got %0d beats expected 4", beats); end
    n_cmp++;
    if (a3 !== 10'd12) begin n_fail++; $display("FAIL abort_beat3_addr: got %0d expected 12", a3); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_rd_en !== 1'b0 || act_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_strobes: got w=%0b a=%0b expected 0 0", w_rd_en, act_rd_en);
    end
    n_cmp++;
    if (arr_active !== 1'b0) begin n_fail++; $display("FAIL abort_arr_active: got %0b expected 0", arr_active); end
    n_cmp++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle: got busy=%0b ready=%0b expected busy=0 ready=1", busy, cfg_ready);
    end
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (res_valid || cfg_err || busy || arr_active) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
  endtask

  task automatic test_rst_mid_drain();
    int found;
    @(posedge clk); #1;
    submit(1, 2, 6, 1, 2);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cyc - t_acc == 7) begin found = 1; break; end
    end
    n_cmp++;
    if (found !== 1 || busy !== 1'b1 || w_rd_en !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_drain: got found=%0d busy=%0b w=%0b expected 1 1 0", found, busy, w_rd_en);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || arr_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: got ready=%0b busy=%0b rv=%0b act=%0b expected 1 0 0 0",
                         cfg_ready, busy, res_valid, arr_active);
    end
    n_cmp++;
    if (arr_precision !== 4'd0 || arr_exp_set !== 5'd0) begin
      n_fail++; $display("FAIL rst_latched: got prec=%0d exp=%0d expected 0 0", arr_precision, arr_exp_set);
    end
    @(posedge clk); #1;
    submit(1, 1, 9, 3, 4);
    capture(40);
    n_cmp++;
    if (o_rv !== 4 + DL) begin n_fail++; $display("FAIL rst_next_job_rv: got %0d expected %0d", o_rv, 4 + DL); end
    n_cmp++;
    if (obs_w.size() != 1 || obs_w[0] !== 10'd4) begin
      n_fail++; $display("FAIL rst_next_job_waddr: got %0d beats expected one beat at 4", obs_w.size());
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_wrap_back_to_back();
    int ks[2]  = '{1, 3};
    int ps[2]  = '{4, 1};
    int abs[2] = '{1023, 1022};
    int wbs[2] = '{1022, 5};
    logic [ADDR_W-1:0] e, o;
    int eb, ob;
    @(posedge clk); #1;
    for (int j = 0; j < 2; j++) begin
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d]_ready: got %0b expected 1", j, cfg_ready); end
      submit(ks[j], ps[j], 3 + j, abs[j], wbs[j]);
      capture(60);
      n_cmp++;
      if (o_clr_first !== 1) begin n_fail++; $display("FAIL b2b[%0d]_clr_cycle: got %0d expected 1", j, o_clr_first); end
      for (int i = 0; exp_w.size() > 0; i++) begin
        e = exp_w.pop_front();
        n_cmp++;
        if (obs_w.size() == 0) begin
          n_fail++; $display("FAIL wrap[%0d]_w_addr[%0d]: got none expected %0d", j, i, e);
        end else begin
          o = obs_w.pop_front();
          if (o !== e) begin n_fail++; $display("FAIL wrap[%0d]_w_addr[%0d]: got %0d expected %0d", j, i, o, e); end
        end
      end
      for (int i = 0; exp_a.size() > 0; i++) begin
        e  = exp_a.pop_front();
        eb = exp_ab.pop_front();
        n_cmp++;
        if (obs_a.size() == 0) begin
          n_fail++; $display("FAIL wrap[%0d]_act[%0d]: got none expected addr %0d", j, i, e);
        end else begin
          o  = obs_a.pop_front();
          ob = obs_ab.pop_front();
          if (o !== e || ob !== eb) begin
            n_fail++;
            $display("FAIL wrap[%0d]_act[%0d]: got addr %0d beat %0d expected addr %0d beat %0d", j, i, o, ob, e, eb);
          end
        end
      end
      n_cmp++;
      if (obs_w.size() != 0 || obs_a.size() != 0) begin
        n_fail++; $display("FAIL wrap[%0d]_extra: got %0d/%0d extra expected 0/0", j, obs_w.size(), obs_a.size());
      end
      n_cmp++;
      if (o_rv !== exp_rv) begin n_fail++; $display("FAIL wrap[%0d]_rv: got %0d expected %0d", j, o_rv, exp_rv); end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_k = '0; cfg_precision = '0; cfg_exp_set = '0;
    cfg_act_base = '0; cfg_w_base = '0; abort = 1'b0; res_ready = 1'b0;
    test_reset();
    test_basic_job();
    test_bad_cfg();
    test_hold_done();
    test_abort();
    test_rst_mid_drain();
    test_wrap_back_to_back();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
